reversi_move_ctrl: RTL and testbench
====================================

// Module: reversi_move_ctrl
// PURPOSE
// Sequences one reversi move against the 64-cell board store. On go, it:
// - checks that the target cell is empty;
// - scans the 8 directions and writes each flipped cell, one write per cycle;
// - places the stone and toggles the side to move.
// Sits between the x/y/go user inputs and the board register bank.
// PARAMETERS
// DIR_MASK  8'hFF  direction enable, bit d = direction d; disabled dirs skipped, 0 cycles
// CNT_W     5      flip counter width; max 18 flips/move
// PORTS
// clk           in   1    system clock
// resetn        in   1    reset, asynchronous, active-high (1 = reset); same sense as board store
// go            in   1    move request, sampled only in IDLE
// x, y          in   3    target column/row; cell idx = {y,x}
// board_in      in   128  cell idx at [2*idx+1:2*idx]: 00 empty, 10 white, 11 black
// wr_en         out  1    board write strobe
// wr_idx        out  6    cell index written
// wr_cell       out  2    cell value written (10/11)
// player_black  out  1    1 = black to move
// busy          out  1    FSM not in IDLE
// done          out  1    1-cycle pulse: legal move completed
// illegal       out  1    1-cycle pulse: move rejected, board untouched
// flip_cnt      out  CNT_W  flips of last move; held until next go
// black_cnt     out  7    black stones (SCORE_EN), else 0
// white_cnt     out  7    white stones (SCORE_EN), else 0
// BEHAVIOUR
// Reset values: IDLE, player_black=1, wr_en/done/illegal/busy=0, flip_cnt=0,
//   counts 2/2 (SCORE_EN) else 0.
// Board store registers writes: board_in reflects a write on the cycle after wr_en.
// go rising in IDLE latches x,y, clears flip_cnt, enters CHECK. go outside IDLE is ignored.
// own = player_black ? 11 : 10; opp = player_black ? 10 : 11.
// Dir order d0..d7, (dx,dy): E(+1,0) NE(+1,-1) N(0,-1) NW(-1,-1) W(-1,0) SW(-1,+1) S(0,+1) SE(+1,+1).
// Coordinates carried as 4-bit signed; outside 0..7 = off board.
// FSM states and transitions:
// - CHECK (1 cyc): target != 00 -> REJECT; else SCAN d = first enabled dir.
// - SCAN (1 cyc/step, k = 1,2..): cell at target+k*dir.
//   - off board or 00 -> NEXTDIR.
//   - opp -> k+1.
//   - own with k==1 -> NEXTDIR.
//   - own with k>=2 -> run = k-1, FLIP.
// - FLIP (run cycles): write own to target+j*dir, j = run..1 descending; flip_cnt += run.
// - NEXTDIR (0 cyc, combinational advance): next enabled dir -> SCAN.
//   - after last dir: flip_cnt == 0 -> REJECT; else PLACE.
// - PLACE (1 cyc): write own at target; player_black toggles on exit; done=1 next cycle; -> IDLE.
// - REJECT (1 cyc): illegal=1; player_black unchanged; no write ever issued; -> IDLE.
// Direction lines from one target are disjoint, so flips never alter a later scan.
// wr_en is high only in FLIP and PLACE, at most one write per cycle.
// Latency go->done = 2 + sum(scan steps) + flips.
// No pass or game-over detection: those are handled by the caller.
// Reset mid-move forces IDLE immediately and drops wr_en. The board store
//   shares resetn, so no partial move survives.
// CONFIGURATION
// SCORE_EN defined:
// - black_cnt/white_cnt are tracked: each flip moves 1 from opp count to own; PLACE adds 1 to own.
// - Counts update in the same cycle as the write.
// SCORE_EN undefined:
// - counters are not built; black_cnt/white_cnt are tied to 0; all other behaviour is identical.
// TESTING
// Start board: idx27=10, 28=11, 35=11, 36=10, all others 00.
// 1. Start board, go x=3 y=2 -> writes (27,11) then (19,11); flip_cnt=1; done; player_black=0;
//    SCORE_EN: 4/1.
// 2. Start board, go x=0 y=0 -> illegal pulse after 8 dir scans, no wr_en, player_black stays 1.
// 3. Start board, go x=3 y=3 (occupied) -> illegal on cycle 2, zero writes.
// 4. White to move, target idx 0, whites at idx 3 and 24, blacks at 1,2,8,16 ->
//    flips E(2,1) then S(16,8); flip_cnt=4; PLACE idx 0 = 10.
// 5. go pulsed again while busy -> ignored; reset asserted mid-FLIP -> IDLE next edge,
//    wr_en=0, player_black=1.
// 6. DIR_MASK=8'h01, scenario 4 -> only E flips; flip_cnt=2.

Source files
------------

// File: rtl/reversi_move_ctrl_if.sv
// User-side and board-store signals of the reversi move sequencer.
// master = requester/board-store side, slave = reversi_move_ctrl.
interface reversi_move_ctrl_if #(
  parameter int unsigned CNT_W = 5
);
  logic             go;
  logic [2:0]       x;
  logic [2:0]       y;
  logic [127:0]     board_in;
  logic             wr_en;
  logic [5:0]       wr_idx;
  logic [1:0]       wr_cell;
  logic             player_black;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] flip_cnt;
  logic [6:0]       black_cnt;
  logic [6:0]       white_cnt;

  modport master (
    output go, x, y, board_in,
    input  wr_en, wr_idx, wr_cell, player_black, busy, done, illegal,
           flip_cnt, black_cnt, white_cnt
  );

  modport slave (
    input  go, x, y, board_in,
    output wr_en, wr_idx, wr_cell, player_black, busy, done, illegal,
           flip_cnt, black_cnt, white_cnt
  );
endinterface

// File: rtl/reversi_move_ctrl.sv
// Sequences one reversi move: empty check, 8-direction scan, flips, placement.
// Define SCORE_EN to build the black/white stone counters; otherwise they read 0.
module reversi_move_ctrl #(
  parameter logic [7:0]  DIR_MASK = 8'hFF,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 resetn,
  reversi_move_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SCAN, S_FLIP, S_PLACE, S_REJECT
  } state_e;

  state_e state_q, state_d;

  logic             go_prev_q;
  logic [2:0]       tx_q, tx_d, ty_q, ty_d;
  logic [2:0]       dir_q, dir_d;
  logic [3:0]       px_q, px_d, py_q, py_d;
  logic [3:0]       step_q, step_d;
  logic             advance;
  logic [3:0]       nd;

  logic             wr_en_q, wr_en_d;
  logic [5:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       wr_cell_q, wr_cell_d;
  logic             player_q, player_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] flip_cnt_q, flip_cnt_d;

  // x step of direction d (E NE N NW W SW S SE), two's complement
  function automatic logic [3:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: return 4'h1;
      3'd3, 3'd4, 3'd5: return 4'hF;
      default:          return 4'h0;
    endcase
  endfunction

  function automatic logic [3:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return 4'hF;
      3'd5, 3'd6, 3'd7: return 4'h1;
      default:          return 4'h0;
    endcase
  endfunction

  // {found, dir}: lowest enabled direction at or above start
  function automatic logic [3:0] next_en(input logic [3:0] start);
    logic       found;
    logic [2:0] d;
    found = 1'b0;
    d     = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (DIR_MASK[i] && (4'(i) >= start)) begin
        found = 1'b1;
        d     = 3'(i);
      end
    end
    return {found, d};
  endfunction

  logic       go_rise;
  logic       off_board;
  logic [1:0] cur_cell, tgt_cell, own, opp;
  logic [3:0] first_en, after_en;

  assign go_rise   = bus.go & ~go_prev_q;
  // Coordinates live in -1..8, so bit 3 alone flags off-board
  assign off_board = px_q[3] | py_q[3];
  assign cur_cell  = bus.board_in[{py_q[2:0], px_q[2:0], 1'b0} +: 2];
  assign tgt_cell  = bus.board_in[{ty_q, tx_q, 1'b0} +: 2];
  assign own       = player_q ? 2'b11 : 2'b10;
  assign opp       = player_q ? 2'b10 : 2'b11;
  assign first_en  = next_en(4'd0);
  assign after_en  = next_en(4'({1'b0, dir_q}) + 4'd1);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus scan datapath; NEXTDIR is the 'advance' path below
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    dir_d   = dir_q;
    px_d    = px_q;
    py_d    = py_q;
    step_d  = step_q;
    advance = 1'b0;
    nd      = after_en;
    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          state_d = S_CHECK;
          tx_d    = bus.x;
          ty_d    = bus.y;
        end
      end
      S_CHECK: begin
        if (tgt_cell != 2'b00) state_d = S_REJECT;
        else begin
          advance = 1'b1;
          nd      = first_en;
        end
      end
      S_SCAN: begin
        if (off_board || cur_cell == 2'b00) advance = 1'b1;
        else if (cur_cell == opp) begin
          px_d   = px_q + dir_dx(dir_q);
          py_d   = py_q + dir_dy(dir_q);
          step_d = step_q + 4'd1;
        end else if (step_q == 4'd1) advance = 1'b1;
        else begin
          state_d = S_FLIP;
          px_d    = px_q - dir_dx(dir_q);
          py_d    = py_q - dir_dy(dir_q);
          step_d  = step_q - 4'd1;
        end
      end
      S_FLIP: begin
        if (step_q == 4'd1) advance = 1'b1;
        else begin
          px_d   = px_q - dir_dx(dir_q);
          py_d   = py_q - dir_dy(dir_q);
          step_d = step_q - 4'd1;
        end
      end
      S_PLACE:  state_d = S_IDLE;
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (advance) begin
      if (nd[3]) begin
        state_d = S_SCAN;
        dir_d   = nd[2:0];
        px_d    = {1'b0, tx_q} + dir_dx(nd[2:0]);
        py_d    = {1'b0, ty_q} + dir_dy(nd[2:0]);
        step_d  = 4'd1;
      end else if (flip_cnt_q == '0) begin
        state_d = S_REJECT;
      end else begin
        state_d = S_PLACE;
        px_d    = {1'b0, tx_q};
        py_d    = {1'b0, ty_q};
      end
    end
  end

  // Registered outputs: each _d reflects the state being entered
  always_comb begin
    wr_en_d    = (state_d == S_FLIP) || (state_d == S_PLACE);
    wr_idx_d   = {py_d[2:0], px_d[2:0]};
    wr_cell_d  = own;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_PLACE);
    illegal_d  = (state_d == S_REJECT);
    player_d   = (state_q == S_PLACE) ? ~player_q : player_q;
    flip_cnt_d = flip_cnt_q;
    if (state_q == S_IDLE && go_rise) flip_cnt_d = '0;
    else if (state_d == S_FLIP)       flip_cnt_d = flip_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      go_prev_q  <= 1'b0;
      tx_q       <= 3'd0;
      ty_q       <= 3'd0;
      dir_q      <= 3'd0;
      px_q       <= 4'd0;
      py_q       <= 4'd0;
      step_q     <= 4'd0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 6'd0;
      wr_cell_q  <= 2'b00;
      player_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      flip_cnt_q <= '0;
    end else begin
      go_prev_q  <= bus.go;
      tx_q       <= tx_d;
      ty_q       <= ty_d;
      dir_q      <= dir_d;
      px_q       <= px_d;
      py_q       <= py_d;
      step_q     <= step_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_cell_q  <= wr_cell_d;
      player_q   <= player_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      flip_cnt_q <= flip_cnt_d;
    end
  end

`ifdef SCORE_EN
  logic [6:0] black_q, black_d, white_q, white_d;

  // Each flip moves one stone from opp to own; placement adds one to own
  always_comb begin
    black_d = black_q;
    white_d = white_q;
    if (state_d == S_FLIP) begin
      if (player_q) begin
        black_d = black_q + 7'd1;
        white_d = white_q - 7'd1;
      end else begin
        white_d = white_q + 7'd1;
        black_d = black_q - 7'd1;
      end
    end else if (state_d == S_PLACE) begin
      if (player_q) black_d = black_q + 7'd1;
      else          white_d = white_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      black_q <= 7'd2;
      white_q <= 7'd2;
    end else begin
      black_q <= black_d;
      white_q <= white_d;
    end
  end

  assign bus.black_cnt = black_q;
  assign bus.white_cnt = white_q;
`else
  assign bus.black_cnt = 7'd0;
  assign bus.white_cnt = 7'd0;
`endif

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_idx       = wr_idx_q;
  assign bus.wr_cell      = wr_cell_q;
  assign bus.player_black = player_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.illegal      = illegal_q;
  assign bus.flip_cnt     = flip_cnt_q;

endmodule

// File: tb/tb_reversi_move_ctrl.sv
// Bench for reversi_move_ctrl: per-cycle trace model of whole moves, random play,
// directed start-board scenarios, mid-move reset and a DIR_MASK=8'h01 instance.
module tb_reversi_move_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  reversi_move_ctrl_if #(.CNT_W(5)) bus0 ();
  reversi_move_ctrl_if #(.CNT_W(5)) bus1 ();

  reversi_move_ctrl #(.DIR_MASK(8'hFF), .CNT_W(5)) dut  (.clk(clk), .resetn(resetn), .bus(bus0));
  reversi_move_ctrl #(.DIR_MASK(8'h01), .CNT_W(5)) dut1 (.clk(clk), .resetn(resetn), .bus(bus1));

  localparam logic [127:0] START = (128'd2 << 54) | (128'd3 << 56) | (128'd3 << 70) | (128'd2 << 72);
  localparam logic [127:0] S4    = (128'd2 << 6) | (128'd2 << 48) | (128'd3 << 2) | (128'd3 << 4)
                                 | (128'd3 << 16) | (128'd3 << 32);
  localparam logic [127:0] B1    = (128'd2 << 2) | (128'd3 << 4);
`ifdef SCORE_EN
  localparam logic [6:0] INIT_CNT = 7'd2;
`else
  localparam logic [6:0] INIT_CNT = 7'd0;
`endif

  // Board store: registers writes, resets with the controller, can be preloaded
  logic [127:0] board;
  logic         load_req = 1'b0;
  logic [127:0] load_val = '0;
  always @(posedge clk or posedge resetn) begin
    if (resetn)        board <= START;
    else if (load_req) board <= load_val;
    else if (bus0.wr_en) board[{bus0.wr_idx, 1'b0} +: 2] <= bus0.wr_cell;
  end
  assign bus0.board_in = board;
  assign bus1.board_in = board;

  typedef struct packed {
    logic       wr_en;
    logic [5:0] wr_idx;
    logic [1:0] wr_cell;
    logic       busy;
    logic       done;
    logic       illegal;
    logic       player_black;
    logic [4:0] flip_cnt;
    logic [6:0] black_cnt;
    logic [6:0] white_cnt;
  } rec_t;

  rec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic       mp;
  logic [4:0] mflip;
  logic [6:0] mblack, mwhite;

  int DX[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
  int DY[8] = '{0, -1, -1, -1, 0, 1, 1, 1};

  function automatic logic [1:0] mcell(input logic [127:0] b, input int cx, input int cy);
    if (cx < 0 || cx > 7 || cy < 0 || cy > 7) return 2'b00;
    return b[(cy * 8 + cx) * 2 +: 2];
  endfunction

  task automatic push(input logic w, input int idx, input logic [1:0] c,
                      input logic b, input logic d, input logic il);
    rec_t r;
    r.wr_en        = w;
    r.wr_idx       = w ? 6'(idx) : 6'd0;
    r.wr_cell      = w ? c : 2'b00;
    r.busy         = b;
    r.done         = d;
    r.illegal      = il;
    r.player_black = mp;
    r.flip_cnt     = mflip;
    r.black_cnt    = mblack;
    r.white_cnt    = mwhite;
    exp_q.push_back(r);
  endtask

  // Stone-count deltas: flip moves one from opp to own, place adds one to own
  task automatic bump(input bit is_flip);
`ifdef SCORE_EN
    if (mp) begin
      mblack = mblack + 7'd1;
      if (is_flip) mwhite = mwhite - 7'd1;
    end else begin
      mwhite = mwhite + 7'd1;
      if (is_flip) mblack = mblack - 7'd1;
    end
`else
    if (is_flip) mflip = mflip;
`endif
  endtask

  // Expected cycle-by-cycle outputs of one move, starting with the CHECK cycle
  task automatic build_trace(input logic [127:0] b, input int tx, input int ty,
                             input logic [7:0] mask, output int len);
    logic [1:0] own, opp, c;
    int k;
    bit scanning, occupied;
    len = exp_q.size();
    own = mp ? 2'b11 : 2'b10;
    opp = mp ? 2'b10 : 2'b11;
    mflip = 5'd0;
    push(0, 0, 2'b00, 1, 0, 0);
    occupied = (mcell(b, tx, ty) != 2'b00);
    if (!occupied) begin
      for (int d = 0; d < 8; d++) begin
        if (mask[d]) begin
          k = 1;
          scanning = 1;
          while (scanning) begin
            c = mcell(b, tx + k * DX[d], ty + k * DY[d]);
            push(0, 0, 2'b00, 1, 0, 0);
            if (c == opp) k++;
            else begin
              scanning = 0;
              if (c == own && k >= 2) begin
                for (int j = k - 1; j >= 1; j--) begin
                  mflip = mflip + 5'd1;
                  bump(1);
                  push(1, (ty + j * DY[d]) * 8 + tx + j * DX[d], own, 1, 0, 0);
                end
              end
            end
          end
        end
      end
    end
    if (occupied || mflip == 5'd0) begin
      push(0, 0, 2'b00, 1, 0, 1);
      push(0, 0, 2'b00, 0, 0, 0);
    end else begin
      bump(0);
      push(1, ty * 8 + tx, own, 1, 0, 0);
      mp = ~mp;
      push(0, 0, 2'b00, 0, 1, 0);
      push(0, 0, 2'b00, 0, 0, 0);
    end
    len = exp_q.size() - len;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  // Single compare process: one trace record per negedge while a move is expected
  task automatic compare_loop();
    rec_t a, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.wr_en        = bus0.wr_en;
        a.wr_idx       = bus0.wr_en ? bus0.wr_idx : 6'd0;
        a.wr_cell      = bus0.wr_en ? bus0.wr_cell : 2'b00;
        a.busy         = bus0.busy;
        a.done         = bus0.done;
        a.illegal      = bus0.illegal;
        a.player_black = bus0.player_black;
        a.flip_cnt     = bus0.flip_cnt;
        a.black_cnt    = bus0.black_cnt;
        a.white_cnt    = bus0.white_cnt;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL trace @%0t: got wr=%b idx=%0d cell=%b busy=%b done=%b ill=%b pb=%b fc=%0d b=%0d w=%0d; expected wr=%b idx=%0d cell=%b busy=%b done=%b ill=%b pb=%b fc=%0d b=%0d w=%0d",
                   $time, a.wr_en, a.wr_idx, a.wr_cell, a.busy, a.done, a.illegal, a.player_black,
                   a.flip_cnt, a.black_cnt, a.white_cnt, e.wr_en, e.wr_idx, e.wr_cell, e.busy,
                   e.done, e.illegal, e.player_black, e.flip_cnt, e.black_cnt, e.white_cnt);
        end
      end
    end
  endtask

  task automatic load_board(input logic [127:0] v);
    @(negedge clk);
    load_val = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_move(input int x, input int y, input bit pulse, output int len);
    int n;
    @(negedge clk);
    bus0.x  = 3'(x);
    bus0.y  = 3'(y);
    bus0.go = 1'b1;
    @(posedge clk);
    #1;
    build_trace(board, x, y, 8'hFF, len);
    bus0.go = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      #1;
      bus0.go = (pulse && n == 0);
      n++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL move_timeout: %0d records still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  logic [7:0] writes1[$];

  task automatic run1(input int x, input int y, output bit got_done, output int n);
    bit got;
    writes1.delete();
    got = 0;
    got_done = 0;
    @(negedge clk);
    bus1.x  = 3'(x);
    bus1.y  = 3'(y);
    bus1.go = 1'b1;
    @(negedge clk);
    bus1.go = 1'b0;
    for (n = 0; n < 100; n++) begin
      if (bus1.wr_en) writes1.push_back({bus1.wr_idx, bus1.wr_cell});
      if (bus1.done || bus1.illegal) begin
        got = 1;
        got_done = bus1.done;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("dut1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int len, n;
    bit dn;
    logic [127:0] rb;
    bus0.go = 1'b0; bus0.x = 3'd0; bus0.y = 3'd0;
    bus1.go = 1'b0; bus1.x = 3'd0; bus1.y = 3'd0;
    mp = 1'b1; mflip = 5'd0; mblack = INIT_CNT; mwhite = INIT_CNT;
    fork compare_loop(); join_none

    repeat (3) @(negedge clk);
    check("rst_player_black", 32'(bus0.player_black), 32'd1);
    check("rst_busy",         32'(bus0.busy), 32'd0);
    check("rst_wr_en",        32'(bus0.wr_en), 32'd0);
    check("rst_done_illegal", 32'({bus0.done, bus0.illegal}), 32'd0);
    check("rst_flip_cnt",     32'(bus0.flip_cnt), 32'd0);
    check("rst_counts",       32'({bus0.black_cnt, bus0.white_cnt}), 32'({INIT_CNT, INIT_CNT}));
    resetn = 1'b0;

    // Occupied target: CHECK, REJECT, idle
    run_move(3, 3, 1, len);
    check("occupied_len", 32'(len), 32'd3);
    // Corner with nothing to flip: 8 single-step scans then reject
    run_move(0, 0, 0, len);
    check("corner_len", 32'(len), 32'd11);
    check("corner_player", 32'(bus0.player_black), 32'd1);
    // Opening move x=3 y=2 flips idx27
    run_move(3, 2, 1, len);
    check("open_len", 32'(len), 32'd14);
    check("open_flip_cnt", 32'(bus0.flip_cnt), 32'd1);
    check("open_player", 32'(bus0.player_black), 32'd0);
    check("open_cell27", 32'(board[54 +: 2]), 32'd3);
    check("open_cell19", 32'(board[38 +: 2]), 32'd3);
`ifdef SCORE_EN
    check("open_counts", 32'({bus0.black_cnt, bus0.white_cnt}), 32'({7'd4, 7'd1}));
`endif

    // Reset in the middle of the first flip of a white move
    load_board(S4);
    @(negedge clk);
    bus0.x = 3'd0; bus0.y = 3'd0; bus0.go = 1'b1;
    @(negedge clk);
    bus0.go = 1'b0;
    n = 0;
    while (!bus0.wr_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached_flip", 32'(bus0.wr_en), 32'd1);
    check("rst_mid_pre_player", 32'(bus0.player_black), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_wr_en", 32'(bus0.wr_en), 32'd0);
    check("rst_mid_busy", 32'(bus0.busy), 32'd0);
    check("rst_mid_player", 32'(bus0.player_black), 32'd1);
    check("rst_mid_flip_cnt", 32'(bus0.flip_cnt), 32'd0);
    @(negedge clk);
    resetn = 1'b0;
    mp = 1'b1; mflip = 5'd0; mblack = INIT_CNT; mwhite = INIT_CNT;

    // Full white move on the two-direction board
    run_move(3, 2, 0, len);
    load_board(S4);
    run_move(0, 0, 1, len);
    check("s4_len", 32'(len), 32'd20);
    check("s4_flip_cnt", 32'(bus0.flip_cnt), 32'd4);
    check("s4_player", 32'(bus0.player_black), 32'd1);
    check("s4_cells", 32'({board[0 +: 2], board[2 +: 2], board[4 +: 2], board[16 +: 2], board[32 +: 2]}),
          32'(10'b10_10_10_10_10));

    // East-only instance: black takes idx1, then white flips only the E line
    load_board(B1);
    run1(0, 0, dn, n);
    check("m1_first_done", 32'(dn), 32'd1);
    check("m1_first_writes", 32'(writes1.size()), 32'd2);
    if (writes1.size() == 2) check("m1_first_seq", 32'({writes1[0], writes1[1]}), 32'({6'd1, 2'b11, 6'd0, 2'b11}));
    load_board(S4);
    run1(0, 0, dn, n);
    check("m1_done", 32'(dn), 32'd1);
    check("m1_latency", 32'(n), 32'd7);
    check("m1_flip_cnt", 32'(bus1.flip_cnt), 32'd2);
    check("m1_writes", 32'(writes1.size()), 32'd3);
    if (writes1.size() == 3)
      check("m1_seq", 32'({writes1[0], writes1[1], writes1[2]}), 32'({6'd2, 2'b10, 6'd1, 2'b10, 6'd0, 2'b10}));
    @(negedge clk);
    check("m1_player", 32'(bus1.player_black), 32'd1);
`ifdef SCORE_EN
    check("m1_counts", 32'({bus1.black_cnt, bus1.white_cnt}), 32'({7'd2, 7'd4}));
`endif

    // Random play, with occasional random or fresh boards
    repeat (250) begin
      if ($urandom_range(0, 15) == 0) load_board(START);
      else if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 64; i++) begin
          case ($urandom_range(0, 3))
            2:       rb[2 * i +: 2] = 2'b10;
            3:       rb[2 * i +: 2] = 2'b11;
            default: rb[2 * i +: 2] = 2'b00;
          endcase
        end
        load_board(rb);
      end
      run_move(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), len);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
